sdes_key_sched: RTL and testbench

Sequential, parametrised S-DES round-key scheduler: it loads a 10-bit key, applies P10, then emits ROUNDS 8-bit subkeys one per handshake. Subkeys come out in encrypt order (K1..KR) or decrypt order (KR..K1) with no key buffer. It sits between the key-load path and the round datapath, which consumes one subkey per round through a valid/ready interface.

---
 rtl/sdes_key_sched.sv | 103 ++++++++++
 tb/tb_sdes_key_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sdes_key_sched.sv
// rtl/sdes_key_sched.sv - S-DES round-key scheduler, emits ROUNDS subkeys over valid/ready
// Optional SDES_KEYGEN_ZEROIZE_EN clears the key state when a schedule completes.
module sdes_key_sched #(
  parameter int ROUNDS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:9] Key,
  input  logic       start,
  input  logic       decrypt,
  output logic [0:7] key_out,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [2:0] round_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, EMIT} state_t;

  // Decrypt starts at the rotation of the last encrypt key and walks backwards.
  localparam logic [2:0] LAST    = 3'(ROUNDS - 1);
  localparam logic [2:0] DEC_ROT = 3'((2 * ROUNDS - 1) % 5);

  state_t     state_q;
  logic [0:9] r_q;
  logic [2:0] count_q;
  logic       dec_q;
  logic       done_q;

  logic [0:9] p10;
  logic [0:9] load_d;
  logic [0:9] adv_d;

  function automatic logic [0:4] rol5(input logic [0:4] x, input logic [2:0] n);
    case (n)
      3'd1:    rol5 = {x[1:4], x[0]};
      3'd2:    rol5 = {x[2:4], x[0:1]};
      3'd3:    rol5 = {x[3:4], x[0:2]};
      3'd4:    rol5 = {x[4], x[0:3]};
      default: rol5 = x;
    endcase
  endfunction

  function automatic logic [0:9] rot_halves(input logic [0:9] r, input logic [2:0] n);
    rot_halves = {rol5(r[0:4], n), rol5(r[5:9], n)};
  endfunction

  assign p10 = {Key[2], Key[4], Key[1], Key[6], Key[3],
                Key[9], Key[0], Key[8], Key[7], Key[5]};

  // Rotating right by 2 within a 5-bit half is a left rotation by 3.
  always_comb begin
    load_d = rot_halves(p10, decrypt ? DEC_ROT : 3'd1);
    adv_d  = rot_halves(r_q, dec_q ? 3'd3 : 3'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      count_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= EMIT;
            r_q     <= load_d;
            count_q <= '0;
            dec_q   <= decrypt;
          end
        end
        EMIT: begin
          if (key_ready) begin
            if (count_q == LAST) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              count_q <= '0;
              dec_q   <= 1'b0;
`ifdef SDES_KEYGEN_ZEROIZE_EN
              r_q     <= '0;
`endif
            end else begin
              r_q     <= adv_d;
              count_q <= count_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_out   = {r_q[5], r_q[2], r_q[6], r_q[3], r_q[7], r_q[4], r_q[9], r_q[8]};
  assign key_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign done      = done_q;
  assign round_idx = dec_q ? (LAST - count_q) : count_q;

endmodule

// File: tb/tb_sdes_key_sched.sv
// tb/tb_sdes_key_sched.sv - directed vector bench for sdes_key_sched (ROUNDS=2 and ROUNDS=4)
module tb_sdes_key_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:9] Key;
  logic       start2, start4;
  logic       decrypt;
  logic       key_ready;

  logic [0:7] key_out2, key_out4;
  logic       key_valid2, key_valid4;
  logic [2:0] round_idx2, round_idx4;
  logic       busy2, busy4, done2, done4;

  logic       sel4;
  logic [0:7] ko;
  logic       kv, bz, dn;
  logic [2:0] ri;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sdes_key_sched #(.ROUNDS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .Key(Key), .start(start2), .decrypt(decrypt),
    .key_out(key_out2), .key_valid(key_valid2), .key_ready(key_ready),
    .round_idx(round_idx2), .busy(busy2), .done(done2)
  );

  sdes_key_sched #(.ROUNDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Key(Key), .start(start4), .decrypt(decrypt),
    .key_out(key_out4), .key_valid(key_valid4), .key_ready(key_ready),
    .round_idx(round_idx4), .busy(busy4), .done(done4)
  );

  always_comb begin
    ko = key_out2;  kv = key_valid2; bz = busy2; dn = done2; ri = round_idx2;
    if (sel4) begin
      ko = key_out4; kv = key_valid4; bz = busy4; dn = done4; ri = round_idx4;
    end
  end

  typedef struct {
    bit          r4;
    bit          dec;
    logic [0:9]  key;
    logic [31:0] keys;   // emission order, first key in the top byte
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic run_sched(input vec_t v);
    int n;
    n = v.r4 ? 4 : 2;
    @(negedge clk);
    sel4 = v.r4; Key = v.key; decrypt = v.dec; key_ready = 1'b1;
    if (v.r4) start4 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; start4 = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("valid", 32'(kv), 32'd1);
      check("key", 32'(ko), 32'(v.keys[31 - 8*i -: 8]));
      check("idx", 32'(ri), v.dec ? 32'(n - 1 - i) : 32'(i));
      check("done_low", 32'(dn), 32'd0);
      if (i < n - 1) @(negedge clk);
    end
    @(negedge clk);
    check("done_pulse", 32'(dn), 32'd1);
    check("busy_off", 32'(bz), 32'd0);
    check("valid_off", 32'(kv), 32'd0);
    @(negedge clk);
    check("done_drop", 32'(dn), 32'd0);
  endtask

  initial begin
    vecs[0] = '{r4: 1'b0, dec: 1'b0, key: 10'b1010000010, keys: {8'b10100100, 8'b01000011, 16'h0}};
    vecs[1] = '{r4: 1'b0, dec: 1'b1, key: 10'b1010000010, keys: {8'b01000011, 8'b10100100, 16'h0}};
    vecs[2] = '{r4: 1'b1, dec: 1'b0, key: 10'b1010000010,
                keys: {8'b10100100, 8'b01000011, 8'b00101000, 8'b10010010}};
    vecs[3] = '{r4: 1'b1, dec: 1'b1, key: 10'b1010000010,
                keys: {8'b10010010, 8'b00101000, 8'b01000011, 8'b10100100}};
    vecs[4] = '{r4: 1'b0, dec: 1'b0, key: 10'b1111111111, keys: {8'hff, 8'hff, 16'h0}};
    vecs[5] = '{r4: 1'b1, dec: 1'b1, key: 10'b0000000000, keys: 32'h0};

    rst_n = 1'b0; Key = '0; start2 = 1'b0; start4 = 1'b0; decrypt = 1'b0;
    key_ready = 1'b1; sel4 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(kv), 32'd0);
    check("rst_busy", 32'(bz), 32'd0);
    check("rst_done", 32'(dn), 32'd0);
    check("rst_idx", 32'(ri), 32'd0);
    check("rst_key", 32'(ko), 32'd0);
    rst_n = 1'b1;
    // key_ready with nothing valid must not move the FSM
    repeat (2) @(negedge clk);
    check("idle_ready_valid", 32'(kv), 32'd0);
    check("idle_ready_done", 32'(dn), 32'd0);

    foreach (vecs[i]) run_sched(vecs[i]);

    // Stall on key 0 with a start pulse that must be ignored
    @(negedge clk);
    sel4 = 1'b0; Key = 10'b1010000010; decrypt = 1'b0; key_ready = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 32'(kv), 32'd1);
      check("stall_key", 32'(ko), 32'b10100100);
      check("stall_idx", 32'(ri), 32'd0);
      if (c == 2) begin
        Key = 10'b0000000000; decrypt = 1'b1; start2 = 1'b1;
      end else begin
        start2 = 1'b0;
      end
      @(negedge clk);
    end
    start2 = 1'b0; decrypt = 1'b0; key_ready = 1'b1;
    check("stall_hold_key", 32'(ko), 32'b10100100);
    @(negedge clk);
    check("stall_k1", 32'(ko), 32'b01000011);
    check("stall_k1_idx", 32'(ri), 32'd1);
    @(negedge clk);
    check("stall_done", 32'(dn), 32'd1);
    @(negedge clk);

    // Back-to-back: start held high across the done cycle
    Key = 10'b1010000010; decrypt = 1'b0; key_ready = 1'b1; start2 = 1'b1;
    @(negedge clk);
    check("b2b_k0", 32'(ko), 32'b10100100);
    @(negedge clk);
    check("b2b_k1", 32'(ko), 32'b01000011);
    @(negedge clk);
    check("b2b_done", 32'(dn), 32'd1);
    check("b2b_gap_valid", 32'(kv), 32'd0);
    @(negedge clk);
    start2 = 1'b0;
    check("b2b_second_valid", 32'(kv), 32'd1);
    check("b2b_second_key", 32'(ko), 32'b10100100);
    check("b2b_second_idx", 32'(ri), 32'd0);
    @(negedge clk);
    check("b2b_second_k1", 32'(ko), 32'b01000011);
    @(negedge clk);
    check("b2b_second_done", 32'(dn), 32'd1);
    @(negedge clk);
`ifdef SDES_KEYGEN_ZEROIZE_EN
    check("idle_key_zeroized", 32'(ko), 32'd0);
`else
    check("idle_key_retained", 32'(ko), 32'b01000011);
`endif

    // Reset between key 0 and key 1
    start2 = 1'b1; key_ready = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("mid_k0", 32'(ko), 32'b10100100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(kv), 32'd0);
    check("mid_rst_busy", 32'(bz), 32'd0);
    check("mid_rst_done", 32'(dn), 32'd0);
    check("mid_rst_key", 32'(ko), 32'd0);
    check("mid_rst_idx", 32'(ri), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(kv), 32'd0);
      check("post_rst_done", 32'(dn), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
